// File: rtl/cc_unit.sv
// Y86-64 execute-stage condition-code unit: ZF/SF/OF register, jXX/cmovXX condition evaluation, update pulse.
// Optional statistics counters (cc_update_count, taken_count) are enabled by defining CC_STATS_EN.
module cc_unit #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_overflow,
  input  logic [3:0]       e_icode,
  input  logic [3:0]       e_ifun,
  input  logic             e_bubble,
  input  logic             set_cc_en,
  output logic [2:0]       cc_out,
  output logic             e_cnd,
  output logic             cc_updated
`ifdef CC_STATS_EN
  ,
  output logic [31:0]      cc_update_count,
  output logic [31:0]      taken_count
`endif
);

  localparam logic [3:0] ICODE_CMOV = 4'd2;
  localparam logic [3:0] ICODE_OPQ  = 4'd6;
  localparam logic [3:0] ICODE_JXX  = 4'd7;

  localparam logic [3:0] C_YES = 4'd0;
  localparam logic [3:0] C_LE  = 4'd1;
  localparam logic [3:0] C_L   = 4'd2;
  localparam logic [3:0] C_E   = 4'd3;
  localparam logic [3:0] C_NE  = 4'd4;
  localparam logic [3:0] C_GE  = 4'd5;
  localparam logic [3:0] C_G   = 4'd6;

  // ifun 0 is addq, ifun 1 is subq; only these can report signed overflow.
  localparam logic [3:0] IFUN_LAST_ARITH = 4'd1;

  logic       we;
  logic       zf_q, sf_q, of_q;
  logic       zf_d, sf_d, of_d;
  logic       sf_xor_of;

  assign we = (e_icode == ICODE_OPQ) & set_cc_en & ~e_bubble;

  assign zf_d = (alu_result == '0);
  assign sf_d = alu_result[WIDTH-1];
  assign of_d = alu_overflow & (e_ifun <= IFUN_LAST_ARITH);

  // Reset leaves ZF set so a conditional evaluated before any OPq behaves as "result was zero".
  // NOTE: state registers use non-blocking (<=) assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zf_q       <= 1'b1;
      sf_q       <= 1'b0;
      of_q       <= 1'b0;
      cc_updated <= 1'b0;
    end else begin
      cc_updated <= we;
      if (we) begin
        zf_q <= zf_d;
        sf_q <= sf_d;
        of_q <= of_d;
      end
    end
  end

  assign cc_out    = {zf_q, sf_q, of_q};
  assign sf_xor_of = sf_q ^ of_q;

  // Evaluated from the registered flags only, so an OPq in E never steers its own condition.
  // NOTE: e_cnd gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    e_cnd = 1'b0;
    if (e_icode == ICODE_CMOV || e_icode == ICODE_JXX) begin
      case (e_ifun)
        C_YES:   e_cnd = 1'b1;
        C_LE:    e_cnd = sf_xor_of | zf_q;
        C_L:     e_cnd = sf_xor_of;
        C_E:     e_cnd = zf_q;
        C_NE:    e_cnd = ~zf_q;
        C_GE:    e_cnd = ~sf_xor_of;
        C_G:     e_cnd = ~sf_xor_of & ~zf_q;
        default: e_cnd = 1'b0;
      endcase
    end
  end

`ifdef CC_STATS_EN
  logic taken;

  assign taken = (e_icode == ICODE_JXX) & ~e_bubble & e_cnd;

  // Saturating event counters; they stop at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cc_update_count <= '0;
      taken_count     <= '0;
    end else begin
      if (we && cc_update_count != 32'hFFFF_FFFF) begin
        cc_update_count <= cc_update_count + 32'd1;
      end
      if (taken && taken_count != 32'hFFFF_FFFF) begin
        taken_count <= taken_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cc_unit.sv
// Self-checking bench for cc_unit: vector table with a post-edge scoreboard, plus reset corner sequences.
// Statistics checks are compiled in when CC_STATS_EN is defined.
module tb_cc_unit;

  logic        clk;
  logic        clk_run;
  logic        rst_n;
  logic [63:0] alu_result;
  logic        alu_overflow;
  logic [3:0]  e_icode;
  logic [3:0]  e_ifun;
  logic        e_bubble;
  logic        set_cc_en;
  logic [2:0]  cc_out;
  logic        e_cnd;
  logic        cc_updated;
`ifdef CC_STATS_EN
  logic [31:0] cc_update_count;
  logic [31:0] taken_count;
`endif

  cc_unit #(.WIDTH(64)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .alu_result   (alu_result),
    .alu_overflow (alu_overflow),
    .e_icode      (e_icode),
    .e_ifun       (e_ifun),
    .e_bubble     (e_bubble),
    .set_cc_en    (set_cc_en),
    .cc_out       (cc_out),
    .e_cnd        (e_cnd),
    .cc_updated   (cc_updated)
`ifdef CC_STATS_EN
    ,
    .cc_update_count (cc_update_count),
    .taken_count     (taken_count)
`endif
  );

  always #5 if (clk_run) clk = ~clk;

  typedef struct {
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [63:0] res;
    logic        ovf;
    logic        en;
    logic        bub;
    logic        exp_cnd;
    logic [2:0]  exp_cc;
    logic        exp_upd;
  } vec_t;

  typedef struct {
    logic [2:0] cc;
    logic       upd;
    int         idx;
  } exp_t;

  localparam int NVEC = 19;
  vec_t vecs [NVEC];
  exp_t sb [$];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] icode, input logic [3:0] ifun, input logic [63:0] res,
                              input logic ovf, input logic en, input logic bub, input logic exp_cnd,
                              input logic [2:0] exp_cc, input logic exp_upd);
    vec_t v;
    v.icode = icode; v.ifun = ifun; v.res = res; v.ovf = ovf; v.en = en; v.bub = bub;
    v.exp_cnd = exp_cnd; v.exp_cc = exp_cc; v.exp_upd = exp_upd;
    return v;
  endfunction

  task automatic drive(input logic [3:0] icode, input logic [3:0] ifun, input logic [63:0] res,
                       input logic ovf, input logic en, input logic bub);
    e_icode = icode; e_ifun = ifun; alu_result = res; alu_overflow = ovf;
    set_cc_en = en; e_bubble = bub;
  endtask

  task automatic idle();
    drive(4'd1, 4'd0, 64'd0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    exp_t e;
`ifdef CC_STATS_EN
    int exp_writes = 0;
    int exp_taken  = 0;
`endif
    // Flags listed as {ZF,SF,OF}; exp_cnd is against the flags present before this row's edge.
    vecs[0]  = mk(4'd7, 4'd3, 64'd0,                    1'b0, 1'b1, 1'b0, 1'b1, 3'b100, 1'b0);
    vecs[1]  = mk(4'd6, 4'd1, 64'd0,                    1'b0, 1'b1, 1'b0, 1'b0, 3'b100, 1'b1);
    vecs[2]  = mk(4'd7, 4'd4, 64'd0,                    1'b0, 1'b1, 1'b0, 1'b0, 3'b100, 1'b0);
    vecs[3]  = mk(4'd6, 4'd0, 64'h8000_0000_0000_0000,  1'b1, 1'b1, 1'b0, 1'b0, 3'b011, 1'b1);
    vecs[4]  = mk(4'd7, 4'd2, 64'd0,                    1'b0, 1'b1, 1'b0, 1'b0, 3'b011, 1'b0);
    vecs[5]  = mk(4'd7, 4'd5, 64'd0,                    1'b0, 1'b1, 1'b0, 1'b1, 3'b011, 1'b0);
    vecs[6]  = mk(4'd7, 4'd1, 64'd0,                    1'b0, 1'b1, 1'b0, 1'b0, 3'b011, 1'b0);
    vecs[7]  = mk(4'd6, 4'd3, 64'h1,                    1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 1'b1);
    vecs[8]  = mk(4'd7, 4'd6, 64'd0,                    1'b0, 1'b1, 1'b0, 1'b1, 3'b000, 1'b0);
    vecs[9]  = mk(4'd2, 4'd0, 64'd0,                    1'b0, 1'b1, 1'b0, 1'b1, 3'b000, 1'b0);
    vecs[10] = mk(4'd7, 4'd7, 64'd0,                    1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0);
    vecs[11] = mk(4'd6, 4'd1, 64'hFFFF_FFFF_FFFF_FFF0,  1'b0, 1'b1, 1'b0, 1'b0, 3'b010, 1'b1);
    vecs[12] = mk(4'd6, 4'd1, 64'd0,                    1'b0, 1'b0, 1'b0, 1'b0, 3'b010, 1'b0);
    vecs[13] = mk(4'd6, 4'd1, 64'd0,                    1'b0, 1'b1, 1'b1, 1'b0, 3'b010, 1'b0);
    vecs[14] = mk(4'd7, 4'd2, 64'd0,                    1'b0, 1'b1, 1'b0, 1'b1, 3'b010, 1'b0);
    vecs[15] = mk(4'd6, 4'd5, 64'd0,                    1'b1, 1'b1, 1'b0, 1'b0, 3'b100, 1'b1);
    vecs[16] = mk(4'd6, 4'd1, 64'd5,                    1'b1, 1'b1, 1'b0, 1'b0, 3'b001, 1'b1);
    vecs[17] = mk(4'd7, 4'd1, 64'd0,                    1'b0, 1'b1, 1'b0, 1'b1, 3'b001, 1'b0);
    vecs[18] = mk(4'd4, 4'd0, 64'd0,                    1'b0, 1'b1, 1'b0, 1'b0, 3'b001, 1'b0);

    clk = 1'b0;
    clk_run = 1'b0;
    rst_n = 1'b1;
    idle();
    drive(4'd7, 4'd3, 64'd0, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset with the clock stopped.
    #2 rst_n = 1'b0;
    #1;
    check("reset_cc_out", 64'(cc_out), 64'(3'b100));
    check("reset_cc_updated", 64'(cc_updated), 64'd0);
    check("reset_je_cnd", 64'(e_cnd), 64'd1);
    #2 rst_n = 1'b1;
    clk_run = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      drive(vecs[i].icode, vecs[i].ifun, vecs[i].res, vecs[i].ovf, vecs[i].en, vecs[i].bub);
      #1;
      check($sformatf("v%0d_e_cnd", i), 64'(e_cnd), 64'(vecs[i].exp_cnd));
      e.cc = vecs[i].exp_cc; e.upd = vecs[i].exp_upd; e.idx = i;
      sb.push_back(e);
`ifdef CC_STATS_EN
      if (vecs[i].exp_upd) exp_writes++;
      if (vecs[i].icode == 4'd7 && !vecs[i].bub && vecs[i].exp_cnd) exp_taken++;
`endif
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check($sformatf("v%0d_cc_out", e.idx), 64'(cc_out), 64'(e.cc));
      check($sformatf("v%0d_cc_updated", e.idx), 64'(cc_updated), 64'(e.upd));
    end

`ifdef CC_STATS_EN
    check("stats_update_count", 64'(cc_update_count), 64'(exp_writes));
    check("stats_taken_count", 64'(taken_count), 64'(exp_taken));
`endif

    // Reset asserted mid-cycle in front of a qualifying OPq edge.
    @(negedge clk);
    drive(4'd6, 4'd0, 64'h8000_0000_0000_0000, 1'b1, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_async_cc_out", 64'(cc_out), 64'(3'b100));
    @(posedge clk);
    #1;
    check("midreset_edge_cc_out", 64'(cc_out), 64'(3'b100));
    check("midreset_edge_cc_updated", 64'(cc_updated), 64'd0);
`ifdef CC_STATS_EN
    check("midreset_update_count", 64'(cc_update_count), 64'd0);
    check("midreset_taken_count", 64'(taken_count), 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    drive(4'd6, 4'd1, 64'd5, 1'b0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    check("post_reset_write_cc_out", 64'(cc_out), 64'(3'b000));
    check("post_reset_write_cc_updated", 64'(cc_updated), 64'd1);
    @(negedge clk);
    idle();
    @(posedge clk);
    #1;
    check("pulse_clears_cc_updated", 64'(cc_updated), 64'd0);

`ifdef CC_STATS_EN
    // Preload one below saturation, then two more writes must stop at all-ones.
    @(negedge clk);
    force dut.cc_update_count = 32'hFFFF_FFFE;
    #1 release dut.cc_update_count;
    drive(4'd6, 4'd0, 64'd1, 1'b0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    check("stats_reach_saturation", 64'(cc_update_count), 64'hFFFF_FFFF);
    @(posedge clk);
    #1;
    check("stats_hold_saturation", 64'(cc_update_count), 64'hFFFF_FFFF);
    @(negedge clk);
    idle();
`endif

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
